serial_pair_serializer: RTL and testbench

Parallel-to-serial transmitter for two operand words. It accepts a pair of WIDTH-bit words (a, b) over a valid/ready handshake and emits them as two bit-synchronous serial streams, one bit per accepted beat. A configurable bit order lets the streams drive either serial comparator variant (LSB-first or MSB-first). Framing marks (first/last) let the downstream consumer restart per word without toggling its reset.

---
 rtl/serial_pkg.sv | 17 +
 rtl/serial_pair_shift.sv | 45 ++++
 rtl/serial_pair_serializer.sv | 94 +++++++++
 tb/tb_serial_pair_serializer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial datapath blocks.
package serial_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } serial_state_e;

  localparam bit ORDER_LSB_FIRST = 1'b0;
  localparam bit ORDER_MSB_FIRST = 1'b1;

  // Bit-counter width; a one-bit word still needs a one-bit counter.
  function automatic int cnt_w(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_pair_shift.sv
// Two-lane loadable shift register. The head bit of each lane is the bit
// currently presented on the serial outputs; shifting moves the next bit in
// the configured order into the head position.
module serial_pair_shift
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_head_a,
  output logic             o_head_b
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  // Load a fresh pair, or move both lanes one bit toward the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (i_load) begin
      r_a <= i_a;
      r_b <= i_b;
    end else if (i_shift) begin
      if (MSB_FIRST) begin
        r_a <= r_a << 1;
        r_b <= r_b << 1;
      end else begin
        r_a <= r_a >> 1;
        r_b <= r_b >> 1;
      end
    end
  end

  assign o_head_a = MSB_FIRST ? r_a[WIDTH-1] : r_a[0];
  assign o_head_b = MSB_FIRST ? r_b[WIDTH-1] : r_b[0];

endmodule

// File: rtl/serial_pair_serializer.sv
// Serializes an (a, b) word pair into two bit-synchronous streams with
// first/last framing. Back-to-back words run with no bubble: the next pair is
// accepted on the last beat of the current word.
module serial_pair_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_a,
  output logic             out_b,
  output logic             out_first,
  output logic             out_last
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  serial_state_e r_state;
  serial_state_e w_state_nxt;
  logic [CW-1:0] r_cnt;

  logic w_busy;
  logic w_last;
  logic w_load;
  logic w_adv;
  logic w_head_a;
  logic w_head_b;

  assign w_busy = (r_state == ST_SHIFT);
  assign w_last = w_busy & (r_cnt == LAST);

  // Ready is also raised on the final beat so a waiting pair loads with no gap.
  assign in_ready = ~rst & (~w_busy | (w_last & out_ready));
  assign w_load   = in_valid & in_ready;
  assign w_adv    = w_busy & out_ready & ~w_load;

  assign out_valid = w_busy;
  assign out_first = w_busy & (r_cnt == '0);
  assign out_last  = w_last;
  assign out_a     = w_busy & w_head_a;
  assign out_b     = w_busy & w_head_b;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: a load always lands in SHIFT; the last taken beat without a
  // new pair drops back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_load) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last & out_ready) w_state_nxt = w_load ? ST_SHIFT : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Bit counter: cleared on load and at end of word, advanced per taken beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (w_adv) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

  serial_pair_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_shift  (w_adv),
    .i_a      (in_a),
    .i_b      (in_b),
    .o_head_a (w_head_a),
    .o_head_b (w_head_b)
  );

endmodule

// File: tb/tb_serial_pair_serializer.sv
// Bench for serial_pair_serializer: three instances (W4 MSB-first, W4
// LSB-first, W1) share stimulus and are each tracked by a queue of expected
// bit pairs built from the word at handshake time.
module tb_serial_pair_serializer;

  localparam int N = 3;
  localparam int WK[N] = '{4, 4, 1};
  localparam bit MK[N] = '{1'b1, 1'b0, 1'b1};

  typedef struct packed {
    logic a;
    logic b;
    logic f;
    logic l;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;

  logic ir[N], ov[N], oa[N], ob[N], of[N], ol[N];

  beat_t q[N][$];
  int    n_pass = 0;
  int    n_tot  = 0;

  always #5 clk = ~clk;

  serial_pair_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .in_a(in_a), .in_b(in_b), .out_valid(ov[0]), .out_ready(out_ready),
    .out_a(oa[0]), .out_b(ob[0]), .out_first(of[0]), .out_last(ol[0]));

  serial_pair_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
    .in_a(in_a), .in_b(in_b), .out_valid(ov[1]), .out_ready(out_ready),
    .out_a(oa[1]), .out_b(ob[1]), .out_first(of[1]), .out_last(ol[1]));

  serial_pair_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
    .in_a(in_a[0:0]), .in_b(in_b[0:0]), .out_valid(ov[2]), .out_ready(out_ready),
    .out_a(oa[2]), .out_b(ob[2]), .out_first(of[2]), .out_last(ol[2]));

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
  endtask

  // One clock: apply inputs, compare every instance against its queue, then
  // advance the queues the way the handshakes of this cycle dictate.
  task automatic step(input logic r, input logic v, input logic rdy,
                      input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    rst = r; in_valid = v; out_ready = rdy; in_a = a; in_b = b;
    #1;
    for (int k = 0; k < N; k++) begin
      logic  e_v, e_r;
      beat_t e;
      e_v = (q[k].size() > 0);
      e   = e_v ? q[k][0] : beat_t'(4'b0);
      e_r = !r && (q[k].size() == 0 || (q[k].size() == 1 && rdy));
      chk($sformatf("inst%0d_ready", k), 9'(ir[k]), 9'(e_r));
      chk($sformatf("inst%0d_bits", k),
          {5'b0, ov[k], oa[k], ob[k], of[k]} | {4'b0, ol[k], 4'b0} << 0,
          {5'b0, e_v, e.a, e.b, e.f} | {4'b0, e.l, 4'b0} << 0);
      if (r) begin
        q[k].delete();
      end else begin
        if (e_v && rdy) void'(q[k].pop_front());
        if (v && e_r) begin
          for (int i = 0; i < WK[k]; i++) begin
            int idx;
            beat_t nb;
            idx  = MK[k] ? (WK[k] - 1 - i) : i;
            nb.a = a[idx];
            nb.b = b[idx];
            nb.f = (i == 0);
            nb.l = (i == WK[k] - 1);
            q[k].push_back(nb);
          end
        end
      end
    end
  endtask

  initial begin
    logic [3:0] sa0, sb0, sa1, sb1;
    logic [8:0] irs, ovs;
    logic       gt;

    // Reset state.
    @(posedge clk);
    step(1, 0, 0, 4'h0, 4'h0);
    chk("reset_in_ready", 9'(ir[0]), 9'd0);
    chk("reset_out_valid", 9'(ov[0]), 9'd0);
    step(0, 0, 1, 4'h0, 4'h0);
    chk("ready_after_reset", 9'(ir[0]), 9'd1);

    // Words 1010 / 0110 in both bit orders, out_ready held high.
    step(0, 1, 1, 4'b1010, 4'b0110);
    sa0 = '0; sb0 = '0; sa1 = '0; sb1 = '0; gt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 4'h0, 4'h0);
      sa0 = {sa0[2:0], oa[0]}; sb0 = {sb0[2:0], ob[0]};
      sa1 = {sa1[2:0], oa[1]}; sb1 = {sb1[2:0], ob[1]};
      gt  = (oa[1] & ~ob[1]) | (~(oa[1] ^ ob[1]) & gt);
      if (i == 0) chk("first_at_T1", {7'b0, of[0], ol[0]}, 9'b10);
      if (i == 3) chk("last_at_T4", {7'b0, of[0], ol[0]}, 9'b01);
    end
    chk("msb_a_seq", 9'(sa0), 9'b1010);
    chk("msb_b_seq", 9'(sb0), 9'b0110);
    chk("lsb_a_seq", 9'(sa1), 9'b0101);
    chk("lsb_b_seq", 9'(sb1), 9'b0110);
    chk("lsb_cmp_a_gt_b", 9'(gt), 9'd1);
    step(0, 0, 1, 4'h0, 4'h0);
    chk("idle_after_word", 9'(ov[0]), 9'd0);

    // Back-to-back words, zero bubble.
    irs = '0; ovs = '0;
    for (int i = 0; i < 9; i++) begin
      if (i == 0)      step(0, 1, 1, 4'hF, 4'h0);
      else if (i < 8)  step(0, 1, 1, 4'h3, 4'h3);
      else             step(0, 0, 1, 4'h0, 4'h0);
      irs = {irs[7:0], ir[0]};
      ovs = {ovs[7:0], ov[0]};
    end
    chk("b2b_in_ready", irs, 9'b100010001);
    chk("b2b_out_valid", ovs, 9'b011111111);
    step(0, 0, 1, 4'h0, 4'h0);

    // Backpressure at cnt=2: three stalled cycles, then resume.
    sa0 = '0;
    step(0, 1, 1, 4'b1010, 4'b0110);
    for (int i = 0; i < 7; i++) begin
      logic rd;
      rd = !(i >= 2 && i <= 4);
      step(0, 0, rd, 4'h0, 4'h0);
      if (ov[0] && rd) sa0 = {sa0[2:0], oa[0]};
      if (i == 4) chk("stall_head_held", {7'b0, oa[0], ol[0]}, 9'b10);
    end
    chk("bp_a_seq", 9'(sa0), 9'b1010);

    // Reset while the word 1100/0011 is at cnt=1.
    step(0, 1, 1, 4'b1100, 4'b0011);
    step(0, 0, 1, 4'h0, 4'h0);
    step(1, 0, 1, 4'h0, 4'h0);
    step(0, 0, 1, 4'h0, 4'h0);
    chk("rst_mid_ov", 9'(ov[0]), 9'd0);
    chk("rst_mid_ready", 9'(ir[0]), 9'd1);
    step(0, 1, 1, 4'b1001, 4'b0101);
    step(0, 0, 1, 4'h0, 4'h0);
    chk("fresh_first_bit", {6'b0, of[0], oa[0], ob[0]}, 9'b110);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 4'h0, 4'h0);

    // Single-bit word on the WIDTH=1 instance.
    step(0, 1, 1, 4'b0001, 4'b0000);
    step(0, 0, 1, 4'h0, 4'h0);
    chk("w1_beat", {4'b0, ov[2], of[2], ol[2], oa[2], ob[2]}, 9'b11110);
    step(0, 0, 1, 4'h0, 4'h0);
    chk("w1_back_idle", {7'b0, ov[2], ir[2]}, 9'b01);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
